matrix_stream_writer: RTL and testbench

//  Producer end of the matrix FIFO: streams one 3x3 convolution frame into the shared FIFO
//  as interleaved {data, filter} words, the order the matrix controller reads them in.

---
 rtl/matrix_stream_writer_if.sv | 47 ++++
 rtl/matrix_stream_writer.sv | 189 ++++++++++++++++++
 tb/tb_matrix_stream_writer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_stream_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_stream_writer_if
// Purpose  : Bundles the data-source handshake, the FIFO write port and the
//            controller start/ready pair seen by matrix_stream_writer.
// Ports    : DIN / DIN_VALID / DIN_READY  valid/ready data source
//            FULL / FIFO_WR_EN / FIFO_IN_PORT  FIFO write side
//            CSTART / C_READY  matrix controller launch and completion
// Modports : master - the writer (drives FIFO writes, DIN_READY, CSTART)
//            slave  - the environment (source, FIFO status, controller)
// Revision : 1.0  initial release
// ============================================================================
interface matrix_stream_writer_if #(
  parameter int BIT_LENGTH = 16
);
  logic [BIT_LENGTH-1:0] DIN;
  logic                  DIN_VALID;
  logic                  DIN_READY;
  logic                  FULL;
  logic                  FIFO_WR_EN;
  logic [BIT_LENGTH-1:0] FIFO_IN_PORT;
  logic                  CSTART;
  logic                  C_READY;

  modport master (
    input  DIN,
    input  DIN_VALID,
    input  FULL,
    input  C_READY,
    output DIN_READY,
    output FIFO_WR_EN,
    output FIFO_IN_PORT,
    output CSTART
  );

  modport slave (
    output DIN,
    output DIN_VALID,
    output FULL,
    output C_READY,
    input  DIN_READY,
    input  FIFO_WR_EN,
    input  FIFO_IN_PORT,
    input  CSTART
  );
endinterface
`default_nettype wire

// File: rtl/matrix_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_stream_writer
// Purpose  : Producer end of the matrix FIFO. Streams one 3x3 convolution
//            frame as interleaved {data, filter} words in the order the matrix
//            controller consumes them. Data arrives on a valid/ready source,
//            filter taps come from an internal register file written while
//            idle. Pulses CSTART once the first word is in the FIFO, then
//            waits for C_READY and pulses DONE.
// Ports    : Clk, Rst          clock, asynchronous active-high reset
//            START             frame request (sampled in IDLE only)
//            FILT_WE/ADDR/DIN  filter tap write port (IDLE only, ADDR 0..8)
//            BUSY              high in any state but IDLE
//            DONE              one-cycle frame-complete pulse
//            bus (master)      DIN/DIN_VALID/DIN_READY, FULL/FIFO_WR_EN/
//                              FIFO_IN_PORT, CSTART/C_READY
// Config   : MATRIX_WRITER_FLIP_EN - when defined, filter words are emitted
//            as filt[8-index] (kernel rotated 180 degrees, true convolution);
//            otherwise filt[index] (correlation order). Timing is identical.
// Revision : 1.0  initial release
// ============================================================================
module matrix_stream_writer #(
  parameter int BIT_LENGTH = 16,
  parameter int PORT_COUNT = 3,
  parameter int NUM_LOOP   = 3,
  parameter int IDX_W      = 4
) (
  input  wire logic                  Clk,
  input  wire logic                  Rst,
  input  wire logic                  START,
  input  wire logic                  FILT_WE,
  input  wire logic [IDX_W-1:0]      FILT_ADDR,
  input  wire logic [BIT_LENGTH-1:0] FILT_DIN,
  output logic                       BUSY,
  output logic                       DONE,
  matrix_stream_writer_if.master     bus
);

  localparam int               c_PAIRS    = PORT_COUNT * NUM_LOOP;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(c_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_DATA  = 3'd1,
    S_WR_FILT  = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  r_cstart;
  logic                  w_cstart_nxt;
  logic [BIT_LENGTH-1:0] r_filt [c_PAIRS];

  logic                  w_filt_wr;
  logic [IDX_W-1:0]      w_tap_sel;
  logic [BIT_LENGTH-1:0] w_tap;
  logic                  w_din_ready;
  logic                  w_wr_en;
  logic [BIT_LENGTH-1:0] w_wr_data;

  // --------------------------------------------------------------------------
  // Filter tap register file. Writes are accepted only while idle so the
  // kernel cannot change under a frame; out-of-range addresses are dropped.
  // --------------------------------------------------------------------------
  assign w_filt_wr = (r_state == S_IDLE) && FILT_WE && (FILT_ADDR <= c_LAST_IDX);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < c_PAIRS; i++) begin
        r_filt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_PAIRS; i++) begin
        if (w_filt_wr && (FILT_ADDR == IDX_W'(i))) begin
          r_filt[i] <= FILT_DIN;
        end
      end
    end
  end

  // Tap selection: mirrored index walks the kernel backwards.
`ifdef MATRIX_WRITER_FLIP_EN
  assign w_tap_sel = c_LAST_IDX - r_idx;
`else
  assign w_tap_sel = r_idx;
`endif

  // Explicit compare-mux keeps the read in range for any IDX_W.
  always_comb begin
    w_tap = '0;
    for (int i = 0; i < c_PAIRS; i++) begin
      if (w_tap_sel == IDX_W'(i)) begin
        w_tap = r_filt[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cstart <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cstart <= w_cstart_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and write-port outputs. Every FIFO write is qualified by
  // !FULL so a full FIFO simply freezes the sequence in place.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cstart_nxt = 1'b0;
    w_din_ready  = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_data    = '0;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_nxt = S_WR_DATA;
          w_idx_nxt   = '0;
        end
      end

      S_WR_DATA: begin
        w_din_ready = !bus.FULL;
        if (bus.DIN_VALID && !bus.FULL) begin
          w_wr_en     = 1'b1;
          w_wr_data   = bus.DIN;
          w_state_nxt = S_WR_FILT;
          // Controller launch follows the frame's very first word, so it
          // never finds the FIFO empty when it starts reading.
          w_cstart_nxt = (r_idx == '0);
        end
      end

      S_WR_FILT: begin
        if (!bus.FULL) begin
          w_wr_en   = 1'b1;
          w_wr_data = w_tap;
          if (r_idx == c_LAST_IDX) begin
            w_state_nxt = S_WAIT_RDY;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_WR_DATA;
          end
        end
      end

      S_WAIT_RDY: begin
        if (bus.C_READY) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.DIN_READY    = w_din_ready;
  assign bus.FIFO_WR_EN   = w_wr_en;
  assign bus.FIFO_IN_PORT = w_wr_data;
  assign bus.CSTART       = r_cstart;
  assign BUSY             = (r_state != S_IDLE);
  assign DONE             = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_matrix_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_stream_writer
// Purpose  : Directed self-checking bench for matrix_stream_writer. Drives
//            whole frames with optional FULL / DIN_VALID stalls, mid-frame
//            START/FILT_WE, and a mid-frame reset; compares the captured FIFO
//            word stream and pulse timing against hand-derived expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_matrix_stream_writer;

  localparam int BL = 16;
  localparam int IW = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          START;
  logic          FILT_WE;
  logic [IW-1:0] FILT_ADDR;
  logic [BL-1:0] FILT_DIN;
  logic          BUSY;
  logic          DONE;

  matrix_stream_writer_if #(.BIT_LENGTH(BL)) bus ();

  matrix_stream_writer #(
    .BIT_LENGTH(BL),
    .PORT_COUNT(3),
    .NUM_LOOP  (3),
    .IDX_W     (IW)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .START    (START),
    .FILT_WE  (FILT_WE),
    .FILT_ADDR(FILT_ADDR),
    .FILT_DIN (FILT_DIN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .bus      (bus.master)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Capture state
  int            cyc_n  = 0;
  int            wcnt   = 0;
  int            cs_n   = 0;
  int            cs_c   = 0;
  int            first_c = 0;
  int            last_c  = 0;
  int            ovf    = 0;
  int            dcnt   = 0;
  int            start_c = 0;
  bit            mon_clr = 1'b0;
  logic [BL-1:0] wq[$];
  logic [BL-1:0] taps[9];

  // Source data: 10, 20, ... 90 advancing on each accepted element
  assign bus.DIN = BL'((dcnt + 1) * 10);

  always @(posedge Clk) begin
    cyc_n = cyc_n + 1;
    if (mon_clr) begin
      wq.delete();
      wcnt = 0;
      cs_n = 0;
      dcnt = 0;
    end else begin
      if (bus.FIFO_WR_EN === 1'b1) begin
        if (bus.FULL === 1'b1) ovf++;
        wq.push_back(bus.FIFO_IN_PORT);
        if (wcnt == 0) first_c = cyc_n;
        last_c = cyc_n;
        wcnt++;
      end
      if (bus.CSTART === 1'b1) begin
        cs_n++;
        cs_c = cyc_n;
      end
      if (bus.DIN_VALID === 1'b1 && bus.DIN_READY === 1'b1) dcnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BL-1:0] exp_tap(input int k);
`ifdef MATRIX_WRITER_FLIP_EN
    return taps[8-k];
`else
    return taps[k];
`endif
  endfunction

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    logic [BL-1:0] e;
    chk({tag, "_len"}, wq.size(), 18);
    for (int k = 0; k < 18; k++) begin
      if (k < wq.size()) begin
        e = (k % 2 == 0) ? BL'((k / 2 + 1) * 10) : exp_tap(k / 2);
        chk($sformatf("%s_w%0d", tag, k), wq[k], e);
      end
    end
  endtask

  // Launch a frame and run until stop_at words are written (or budget ends).
  // full_at/valid_at: word count at which a 3-cycle FULL / 2-cycle !VALID
  // stall begins; mid_at: word count at which START+FILT_WE are poked.
  task automatic run_frame(input int full_at, input int valid_at, input int mid_at,
                           input bit we, input logic [IW-1:0] wa, input logic [BL-1:0] wd,
                           input int stop_at);
    int fl = 0, vl = 0;
    bit fd = 0, vd = 0, md = 0, to = 1;
    mon_clear();
    START = 1'b1; FILT_WE = we; FILT_ADDR = wa; FILT_DIN = wd;
    tick();
    start_c = cyc_n;
    START = 1'b0; FILT_WE = 1'b0;
    for (int it = 0; it < 60; it++) begin
      if (wcnt >= stop_at) begin
        to = 0;
        break;
      end
      if (full_at == wcnt && !fd) begin fl = 3; fd = 1; end
      if (valid_at == wcnt && !vd) begin vl = 2; vd = 1; end
      bus.FULL      = (fl > 0);
      bus.DIN_VALID = !(vl > 0);
      if (mid_at == wcnt && !md) begin
        md = 1; START = 1'b1; FILT_WE = 1'b1; FILT_ADDR = '0; FILT_DIN = 16'hFFFF;
      end else begin
        START = 1'b0; FILT_WE = 1'b0;
      end
      #1;
      if (fl > 0) begin
        chk("full_no_wr", bus.FIFO_WR_EN, 0);
        chk("full_no_rdy", bus.DIN_READY, 0);
        fl--;
      end
      if (vl > 0) begin
        chk("stall_rdy", bus.DIN_READY, 1);
        chk("stall_no_wr", bus.FIFO_WR_EN, 0);
        vl--;
      end
      @(posedge Clk);
      #2;
    end
    chk("frame_timeout", to, 0);
    START = 1'b0; FILT_WE = 1'b0; bus.FULL = 1'b0; bus.DIN_VALID = 1'b1;
  endtask

  // In WAIT_RDY: raise C_READY, expect a single-cycle DONE, then IDLE.
  task automatic finish_frame(input string tag);
    chk({tag, "_wait_busy"}, BUSY, 1);
    chk({tag, "_wait_done"}, DONE, 0);
    bus.C_READY = 1'b1;
    tick();
    chk({tag, "_done_hi"}, DONE, 1);
    bus.C_READY = 1'b0;
    tick();
    chk({tag, "_done_lo"}, DONE, 0);
    chk({tag, "_idle"}, BUSY, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; START = 1'b0; FILT_WE = 1'b0; FILT_ADDR = '0; FILT_DIN = '0;
    bus.DIN_VALID = 1'b1; bus.FULL = 1'b0; bus.C_READY = 1'b0;
    for (int i = 0; i < 9; i++) taps[i] = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_cstart", bus.CSTART, 0);
    chk("rst_rdy", bus.DIN_READY, 0);
    chk("rst_wr", bus.FIFO_WR_EN, 0);
    Rst = 1'b0;
    tick();

    // Load taps 1..9
    for (int i = 0; i < 9; i++) begin
      FILT_WE = 1'b1; FILT_ADDR = IW'(i); FILT_DIN = BL'(i + 1);
      taps[i] = BL'(i + 1);
      tick();
    end
    FILT_WE = 1'b0;
    chk("idle_rdy", bus.DIN_READY, 0);

    // T1: no stalls
    run_frame(-1, -1, -1, 1'b0, '0, '0, 18);
    check_stream("t1");
    chk("t1_first_lat", first_c - start_c, 1);
    chk("t1_span", last_c - first_c, 17);
    chk("t1_cstart_n", cs_n, 1);
    chk("t1_cstart_t", cs_c - first_c, 1);
    tick(); tick();
    chk("t1_hold_busy", BUSY, 1);
    chk("t1_no_extra", wcnt, 18);
    finish_frame("t1");

    // T2: FULL for 3 cycles after write 5
    run_frame(5, -1, -1, 1'b0, '0, '0, 18);
    check_stream("t2");
    chk("t2_span", last_c - first_c, 20);
    chk("t2_cstart_n", cs_n, 1);
    finish_frame("t2");

    // T3: DIN_VALID low 2 cycles at index 4; C_READY high during writes
    bus.C_READY = 1'b1;
    run_frame(-1, 8, -1, 1'b0, '0, '0, 18);
    check_stream("t3");
    chk("t3_span", last_c - first_c, 19);
    finish_frame("t3");

    // T4: START + FILT_WE mid-frame are ignored
    run_frame(-1, -1, 6, 1'b0, '0, '0, 18);
    check_stream("t4");
    finish_frame("t4");
    tick(); tick();
    chk("t4_no_restart", BUSY, 0);
    chk("t4_no_writes", wcnt, 18);
    // Out-of-range tap addresses are dropped
    FILT_WE = 1'b1; FILT_ADDR = 4'd9;  FILT_DIN = 16'hBEEF; tick();
    FILT_ADDR = 4'd15; tick();
    FILT_WE = 1'b0;
    run_frame(-1, -1, -1, 1'b0, '0, '0, 18);
    check_stream("t4b");
    finish_frame("t4b");

    // T5: reset after write 7
    run_frame(-1, -1, -1, 1'b0, '0, '0, 7);
    chk("t5_pre_busy", BUSY, 1);
    Rst = 1'b1;
    #1;
    chk("t5_rst_wr", bus.FIFO_WR_EN, 0);
    chk("t5_rst_rdy", bus.DIN_READY, 0);
    chk("t5_rst_cstart", bus.CSTART, 0);
    chk("t5_rst_busy", BUSY, 0);
    chk("t5_rst_done", DONE, 0);
    @(posedge Clk);
    #2;
    Rst = 1'b0;
    tick(); tick();
    chk("t5_no_writes", wcnt, 7);
    chk("t5_idle", BUSY, 0);
    for (int i = 0; i < 9; i++) taps[i] = '0;
    // START together with a tap write: new tap must be used
    taps[0] = 16'h1234;
    run_frame(-1, -1, -1, 1'b1, '0, 16'h1234, 18);
    check_stream("t5");
    chk("t5_cstart_n", cs_n, 1);
    finish_frame("t5");

    chk("no_overflow", ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
